pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_ras.sv | 44 ++++
 rtl/pc_sequencer.sv | 82 ++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared branch-op encoding and PC step for the PC sequencer and its RAS.
// Pure definitions; no logic, no latency, no flow control.
// Used by pc_sequencer (PC_SEQ_RAS_EN selects whether the RAS is built).
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_B    = 3'd1,
    OP_CBZ  = 3'd2,
    OP_CBNZ = 3'd3,
    OP_BL   = 3'd4,
    OP_BR   = 3'd5,
    OP_RET  = 3'd6,
    OP_RSVD = 3'd7
  } br_op_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
// Latency: push/pop committed on the rising edge, top/empty registered (no bypass).
// Backpressure: none; the caller gates push/pop (stall) before they reach here.
module pc_ras #(
  parameter int PC_W  = 64,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  // ptr is the next write slot, so the most recent entry sits one below it
  assign top = mem[ptr - PW'(1)];

  always_ff @(posedge CLK) begin
    if (reset) begin
      ptr   <= '0;
      cnt   <= '0;
      empty <= 1'b1;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
      empty    <= 1'b0;
    end else if (pop && (cnt != '0)) begin
      ptr   <= ptr - PW'(1);
      cnt   <= cnt - CW'(1);
      empty <= (cnt == CW'(1));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: SEQ/B/CBZ/CBNZ/BL/BR/RET; return-address stack when PC_SEQ_RAS_EN is defined.
// Latency: NextPC/taken combinational, CurrentPC updates one edge later.
// Backpressure: stall=1 freezes CurrentPC and the RAS; reset overrides stall.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W      = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [PC_W-1:0] startPC,
  input  logic            stall,
  input  logic [2:0]      br_op,
  input  logic            ALUZero,
  input  logic [PC_W-1:0] SignExtImm64,
  input  logic [PC_W-1:0] RegTarget,
  output logic [PC_W-1:0] CurrentPC,
  output logic [PC_W-1:0] NextPC,
  output logic [PC_W-1:0] LinkAddr,
  output logic            taken,
  output logic            ras_empty
);

  br_op_e          op;
  logic [PC_W-1:0] seq_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] reg_tgt;
  logic [PC_W-1:0] ret_tgt;

  assign op       = br_op_e'(br_op);
  assign seq_tgt  = CurrentPC + PC_W'(PC_INC);
  assign br_tgt   = CurrentPC + (SignExtImm64 << 2);
  assign reg_tgt  = RegTarget & ~PC_W'(3);
  assign LinkAddr = seq_tgt;

`ifdef PC_SEQ_RAS_EN
  logic [PC_W-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;

  assign ras_push = (op == OP_BL) && !stall;
  assign ras_pop  = (op == OP_RET) && !stall && !ras_empty;
  assign ret_tgt  = ras_empty ? reg_tgt : ras_top;

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (LinkAddr),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  assign ret_tgt   = reg_tgt;
  assign ras_empty = 1'b1;
`endif

  always_comb begin
    NextPC = seq_tgt;
    case (op)
      OP_B, OP_BL: NextPC = br_tgt;
      OP_CBZ:      if (ALUZero)  NextPC = br_tgt;
      OP_CBNZ:     if (!ALUZero) NextPC = br_tgt;
      OP_BR:       NextPC = reg_tgt;
      OP_RET:      NextPC = ret_tgt;
      default:     NextPC = seq_tgt;
    endcase
  end

  assign taken = (NextPC != seq_tgt);

  always_ff @(posedge CLK) begin
    if (reset)       CurrentPC <= startPC;
    else if (!stall) CurrentPC <= NextPC;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        CLK;
  logic        reset;
  logic [63:0] startPC;
  logic        stall;
  logic [2:0]  br_op;
  logic        ALUZero;
  logic [63:0] SignExtImm64;
  logic [63:0] RegTarget;
  logic [63:0] CurrentPC;
  logic [63:0] NextPC;
  logic [63:0] LinkAddr;
  logic        taken;
  logic        ras_empty;

  pc_sequencer #(.PC_W(64), .RAS_DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .startPC      (startPC),
    .stall        (stall),
    .br_op        (br_op),
    .ALUZero      (ALUZero),
    .SignExtImm64 (SignExtImm64),
    .RegTarget    (RegTarget),
    .CurrentPC    (CurrentPC),
    .NextPC       (NextPC),
    .LinkAddr     (LinkAddr),
    .taken        (taken),
    .ras_empty    (ras_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC plus the stack as a plain queue.
  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_next();
    logic [63:0] seq, br, rg;
    seq = m_pc + 64'd4;
    br  = m_pc + SignExtImm64 * 64'd4;
    rg  = {RegTarget[63:2], 2'b00};
    case (br_op)
      3'd1, 3'd4: return br;
      3'd2:       return ALUZero ? br : seq;
      3'd3:       return ALUZero ? seq : br;
      3'd5:       return rg;
      3'd6:       return (RAS_EN && m_ras.size() > 0) ? m_ras[m_ras.size()-1] : rg;
      default:    return seq;
    endcase
  endfunction

  task automatic compare_all();
    logic [63:0] nx;
    nx = exp_next();
    check("CurrentPC", CurrentPC, m_pc);
    check("NextPC", NextPC, nx);
    check("LinkAddr", LinkAddr, m_pc + 64'd4);
    check("taken", 64'(taken), 64'(nx != m_pc + 64'd4));
    check("ras_empty", 64'(ras_empty), 64'(m_ras.size() == 0));
  endtask

  task automatic model_edge();
    logic [63:0] nx;
    nx = exp_next();
    if (reset) begin
      m_pc = startPC;
      m_ras.delete();
      m_valid = 1'b1;
    end else if (!stall) begin
      if (RAS_EN && br_op == 3'd4) begin
        m_ras.push_back(m_pc + 64'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (RAS_EN && br_op == 3'd6 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
      m_pc = nx;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge CLK);
    if (m_valid) compare_all();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic setin(input logic rst, input logic [63:0] sp, input logic st, input logic [2:0] op,
                       input logic z, input logic [63:0] imm, input logic [63:0] rt);
    reset = rst; startPC = sp; stall = st; br_op = op; ALUZero = z; SignExtImm64 = imm; RegTarget = rt;
  endtask

  task automatic do_reset(input logic [63:0] sp);
    setin(1'b1, sp, 1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    tick();
  endtask

  initial begin
    setin(1'b1, 64'h400000, 1'b1, 3'd4, 1'b0, 64'd0, 64'd0);
    tick();
    check("reset_pc", CurrentPC, 64'h400000);
    check("reset_ras_empty", 64'(ras_empty), 64'd1);
    setin(1'b0, 64'h0, 1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    tick(); check("seq1", CurrentPC, 64'h400004);
    tick(); check("seq2", CurrentPC, 64'h400008);
    tick(); check("seq3", CurrentPC, 64'h40000C);

    do_reset(64'h1000);
    setin(1'b0, 64'h0, 1'b0, 3'd2, 1'b1, -64'sd2, 64'd0); #1;
    check("cbz_next", NextPC, 64'h0FF8);
    check("cbz_taken", 64'(taken), 64'd1);
    tick(); check("cbz_pc", CurrentPC, 64'h0FF8);
    do_reset(64'h1000);
    setin(1'b0, 64'h0, 1'b0, 3'd3, 1'b1, -64'sd2, 64'd0); #1;
    check("cbnz_next", NextPC, 64'h1004);
    check("cbnz_taken", 64'(taken), 64'd0);
    tick();
    do_reset(64'h1000);
    setin(1'b0, 64'h0, 1'b0, 3'd1, 1'b0, 64'h10, 64'd0); #1;
    check("b_next", NextPC, 64'h1040);
    tick();

    do_reset(64'h0);
    setin(1'b0, 64'h0, 1'b0, 3'd1, 1'b0, -64'sd1, 64'd0); #1;
    check("b_wrap", NextPC, 64'hFFFF_FFFF_FFFF_FFFC);
    setin(1'b0, 64'h0, 1'b0, 3'd5, 1'b0, -64'sd1, 64'h2003); #1;
    check("br_align", NextPC, 64'h2000);
    tick(); check("br_pc", CurrentPC, 64'h2000);

    // Five calls overflow a 4-deep stack; the oldest return is lost.
    do_reset(64'h100);
    for (int i = 0; i < 5; i++) begin
      setin(1'b0, 64'h0, 1'b0, 3'd4, 1'b0, 64'h40, 64'h0);
      tick();
    end
    check("bl_chain_pc", CurrentPC, 64'h600);
    for (int i = 0; i < 5; i++) begin
      logic [63:0] want;
      want = (RAS_EN && i < 4) ? 64'h504 - 64'(i) * 64'h100 : 64'h9000;
      setin(1'b0, 64'h0, 1'b0, 3'd6, 1'b0, 64'h0, 64'h9000); #1;
      check("ret_target", NextPC, want);
      if (i == 4) check("ret_empty", 64'(ras_empty), 64'd1);
      tick();
    end

    do_reset(64'h100);
    for (int i = 0; i < 3; i++) begin
      setin(1'b0, 64'h0, 1'b1, 3'd4, 1'b0, 64'h40, 64'h0);
      tick();
      check("stall_pc", CurrentPC, 64'h100);
      check("stall_no_push", 64'(ras_empty), 64'd1);
    end
    setin(1'b0, 64'h0, 1'b0, 3'd4, 1'b0, 64'h40, 64'h0);
    tick();
    check("unstall_pc", CurrentPC, 64'h200);
    check("unstall_push", 64'(ras_empty), RAS_EN ? 64'd0 : 64'd1);
    setin(1'b0, 64'h0, 1'b0, 3'd6, 1'b0, 64'h0, 64'h8001); #1;
    check("unstall_ret", NextPC, RAS_EN ? 64'h104 : 64'h8000);
    tick();

    do_reset(64'h100);
    for (int i = 0; i < 2; i++) begin
      setin(1'b0, 64'h0, 1'b0, 3'd4, 1'b0, 64'h40, 64'h0);
      tick();
    end
    do_reset(64'h100);
    setin(1'b0, 64'h0, 1'b0, 3'd6, 1'b0, 64'h0, 64'h7000); #1;
    check("ret_after_reset", NextPC, 64'h7000);
    tick();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      setin(($urandom_range(0, 49) == 0), {$urandom, $urandom, 2'b00} >> 2,
            ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            (n % 3 == 0) ? {$urandom, $urandom} : {{32{r[31]}}, r},
            {$urandom, $urandom});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
